microc_stk: RTL and testbench
=============================

Name: microc_stk

Overview:
- Parametrised successor to the team's single-cycle, data-memory-less microcontroller datapath.
- Data width, PC width, I/O port count and instruction width are generic.
- Adds a hardware return-address stack (call/return) with overflow/underflow flags.
- Zero flag updates only on ALU write-back.
- Instruction fetch is external: the block drives `pc` and receives `instr` combinationally from program memory. The control unit drives the `s_*`, `op` and `we3` signals from `opcode`.

Parameters:
- DWIDTH, 8, data/register/port width.
- PC_W, 10, program counter width.
- IW, 16, instruction width; legal only if IW >= 12, IW >= 4+DWIDTH and IW >= 6+PC_W.
- NPORTS, 4, number of input ports and number of output ports; power of two, >= 2. PSW = log2(NPORTS).
- STACK_DEPTH, 8, return-stack entries; >= 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  IW  instruction from program memory at address pc.
- s_inc  in  1  1: PC+1; 0: jump to target.
- s_inm  in  1  1: write-back source is the immediate; 0: ALU result.
- we3  in  1  register-file write enable.
- s_e  in  1  1: write-back source is the selected input port (overrides s_inm).
- s_s  in  1  write the selected output port.
- s_src  in  1  output-port data: 1 = rd2, 0 = immediate.
- s_call  in  1  push PC+1, jump to target.
- s_ret  in  1  pop into PC.
- op  in  3  ALU operation.
- d_in  in  NPORTS*DWIDTH  input ports; port k = bits [k*DWIDTH +: DWIDTH].
- pc  out  PC_W  current PC.
- opcode  out  6  instr[5:0].
- zero  out  1  registered zero flag.
- d_out  out  NPORTS*DWIDTH  registered output ports.
- stk_ovf  out  1  sticky stack overflow.
- stk_unf  out  1  sticky stack underflow.

Behaviour:
- Instruction fields:
  - wa = instr[IW-1 -: 4], ra2 = instr[IW-5 -: 4], ra1 = instr[IW-9 -: 4].
  - imm = instr[IW-5 -: DWIDTH]; target = instr[IW-1 -: PC_W]; port = instr[6 +: PSW].
  - Output-port immediate = instr[IW-1 -: DWIDTH].
- Register file:
  - 16 x DWIDTH, two combinational reads, one write at the rising edge.
  - r0 always reads 0; writes to r0 are ignored.
- ALU (combinational, modulo 2^DWIDTH): 000 A; 001 ~A; 010 A+B; 011 A-B; 100 A&B; 101 A|B; 110 -A; 111 -B. A = rd1, B = rd2.
- Write-back data: s_e ? d_in[port] : (s_inm ? imm : alu).
- zero flag: loads (alu==0) only when we3=1, s_e=0 and s_inm=0; otherwise holds.
- Output port: when s_s=1, d_out[port] <= (s_src ? rd2 : out-imm). Other ports hold.
- Next PC, in priority order:
  1. s_call → target.
  2. s_ret with stack non-empty → top-of-stack.
  3. s_inc → PC+1.
  4. otherwise → target.
  - PC+1 wraps from 2^PC_W-1 to 0.
- Stack:
  - LIFO with pointer sp in 0..STACK_DEPTH.
  - Call: push (PC+1 mod 2^PC_W), sp+1.
  - Call when full: jump still taken, push discarded, sp unchanged, stk_ovf <= 1.
  - Ret when empty: PC <= PC+1, sp unchanged, stk_unf <= 1.
  - s_call and s_ret in the same cycle: call executes, ret ignored.
- Single cycle: every architectural update commits at one rising edge.
- Reset (asserted, asynchronous):
  - pc=0, sp=0, zero=0, d_out=0, stk_ovf=0, stk_unf=0, all registers 0.
  - Reset asserted mid-call discards the push.
  - Flags clear only on reset.

Optional Feature:
- MICROC_CARRY_EN defined:
  - Adds output port `carry` (1 bit, reset 0).
  - Loaded under the same condition as zero.
  - Value: carry-out of A+B for op 010; NOT borrow (A>=B unsigned) for op 011; 0 for all other ops.
- Undefined: no carry port, no carry logic.

Test Plan:
- Reset release, s_inc=1 for 5 cycles → pc steps 0,1,2,3,4,5; d_out=0; flags=0.
- DWIDTH=8: load r1=0x0F and r2=0xF1 via s_inm, then op=010 into r3 → r3=0x00, zero=1. A following s_inm write does not change zero. With MICROC_CARRY_EN, carry=1.
- s_e=1, port=2, d_in[2]=0xA5 → register gets 0xA5. Then s_s=1, s_src=1, port=3 → d_out[3]=0xA5 next cycle; other ports unchanged.
- Call at pc=0x010, target 0x200 → pc=0x200. Ret → pc=0x011. Nested calls to depth 8, then 8 rets → correct addresses in reverse order.
- 9th nested call → jump taken, stk_ovf=1. Ret on empty stack → pc+1, stk_unf=1.
- PC at 0x3FF with s_inc → 0x000. s_call and s_ret together → call behaviour. Reset asserted mid-sequence → all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/microc_stk.sv
// microc_stk: single-cycle microcontroller datapath with a hardware return-address stack.
// Latency: fetch fields and ALU are combinational; every architectural update commits at one rising edge.
// Backpressure: none, one instruction retires per clock. Optional carry flag under MICROC_CARRY_EN.
module microc_stk #(
    parameter int DWIDTH      = 8,
    parameter int PC_W        = 10,
    parameter int IW          = 16,
    parameter int NPORTS      = 4,
    parameter int STACK_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IW-1:0]              instr,
    input  logic                       s_inc,
    input  logic                       s_inm,
    input  logic                       we3,
    input  logic                       s_e,
    input  logic                       s_s,
    input  logic                       s_src,
    input  logic                       s_call,
    input  logic                       s_ret,
    input  logic [2:0]                 op,
    input  logic [NPORTS*DWIDTH-1:0]   d_in,
    output logic [PC_W-1:0]            pc,
    output logic [5:0]                 opcode,
    output logic                       zero,
    output logic [NPORTS*DWIDTH-1:0]   d_out,
    output logic                       stk_ovf,
    output logic                       stk_unf
`ifdef MICROC_CARRY_EN
    ,
    output logic                       carry
`endif
);

    localparam int PSW = $clog2(NPORTS);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SIW = $clog2(STACK_DEPTH);
    localparam logic [PC_W-1:0] PC_ONE  = 1;
    localparam logic [SPW-1:0]  SP_ONE  = 1;
    localparam logic [SPW-1:0]  SP_FULL = SPW'(STACK_DEPTH);

    // Instruction fields; they deliberately overlap, the control unit picks which one matters.
    logic [3:0]        wa, ra1, ra2;
    logic [DWIDTH-1:0] imm, oimm;
    logic [PC_W-1:0]   target;
    logic [PSW-1:0]    port;

    assign wa     = instr[IW-1 -: 4];
    assign ra2    = instr[IW-5 -: 4];
    assign ra1    = instr[IW-9 -: 4];
    assign imm    = instr[IW-5 -: DWIDTH];
    assign oimm   = instr[IW-1 -: DWIDTH];
    assign target = instr[IW-1 -: PC_W];
    assign port   = instr[6 +: PSW];
    assign opcode = instr[5:0];

    logic [DWIDTH-1:0] rf    [16];
    logic [DWIDTH-1:0] din_a [NPORTS];
    logic [DWIDTH-1:0] out_q [NPORTS];
    logic [DWIDTH-1:0] rd1, rd2, alu_res, wb_dat;
    logic [DWIDTH:0]   sum, diff;
    logic              flag_ld;

    for (genvar k = 0; k < NPORTS; k++) begin : g_ports
        assign din_a[k]                  = d_in[k*DWIDTH +: DWIDTH];
        assign d_out[k*DWIDTH +: DWIDTH] = out_q[k];
    end

    // r0 is hard-wired to zero on both read ports
    assign rd1 = (ra1 == 4'd0) ? '0 : rf[ra1];
    assign rd2 = (ra2 == 4'd0) ? '0 : rf[ra2];

    // One extra bit on add/sub exposes carry-out and borrow
    assign sum  = {1'b0, rd1} + {1'b0, rd2};
    assign diff = {1'b0, rd1} - {1'b0, rd2};

    // ALU, all results modulo 2^DWIDTH
    always_comb begin
        alu_res = rd1;
        case (op)
            3'b000:  alu_res = rd1;
            3'b001:  alu_res = ~rd1;
            3'b010:  alu_res = sum[DWIDTH-1:0];
            3'b011:  alu_res = diff[DWIDTH-1:0];
            3'b100:  alu_res = rd1 & rd2;
            3'b101:  alu_res = rd1 | rd2;
            3'b110:  alu_res = -rd1;
            default: alu_res = -rd2;
        endcase
    end

    assign wb_dat  = s_e ? din_a[port] : (s_inm ? imm : alu_res);
    assign flag_ld = we3 & ~s_e & ~s_inm;

    // Register file write; r0 writes are dropped so it stays zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (we3 && (wa != 4'd0)) begin
            rf[wa] <= wb_dat;
        end
    end

    // Output port latch; unselected ports hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPORTS; i++) out_q[i] <= '0;
        end else if (s_s) begin
            out_q[port] <= s_src ? rd2 : oimm;
        end
    end

    // Zero flag only follows ALU write-backs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       zero <= 1'b0;
        else if (flag_ld) zero <= (alu_res == '0);
    end

`ifdef MICROC_CARRY_EN
    logic carry_nxt;
    assign carry_nxt = (op == 3'b010) ? sum[DWIDTH] :
                       (op == 3'b011) ? ~diff[DWIDTH] : 1'b0;

    // Carry shares the zero flag's load condition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       carry <= 1'b0;
        else if (flag_ld) carry <= carry_nxt;
    end
`else
    logic unused_carry_bits;
    assign unused_carry_bits = sum[DWIDTH] ^ diff[DWIDTH];
`endif

    // Return stack and PC sequencing
    logic [PC_W-1:0] stk [STACK_DEPTH];
    logic [SPW-1:0]  sp_q, sp_m1;
    logic [PC_W-1:0] pc_inc, pc_nxt;
    logic            stk_full, stk_empty, do_push, do_pop, set_ovf, set_unf;

    assign stk_full  = (sp_q == SP_FULL);
    assign stk_empty = (sp_q == '0);
    assign sp_m1     = sp_q - SP_ONE;
    assign pc_inc    = pc + PC_ONE;

    // Call beats ret; an empty-stack ret falls through to PC+1
    always_comb begin
        pc_nxt  = pc_inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (s_call) begin
            pc_nxt  = target;
            do_push = ~stk_full;
            set_ovf = stk_full;
        end else if (s_ret && !stk_empty) begin
            pc_nxt  = stk[sp_m1[SIW-1:0]];
            do_pop  = 1'b1;
        end else if (s_ret) begin
            pc_nxt  = pc_inc;
            set_unf = 1'b1;
        end else if (s_inc) begin
            pc_nxt  = pc_inc;
        end else begin
            pc_nxt  = target;
        end
    end

    // PC, stack pointer and sticky stack flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= '0;
            sp_q    <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (do_push)     sp_q <= sp_q + SP_ONE;
            else if (do_pop) sp_q <= sp_m1;
            if (set_ovf) stk_ovf <= 1'b1;
            if (set_unf) stk_unf <= 1'b1;
        end
    end

    // Stack storage needs no reset: entries above sp are never read
    always_ff @(posedge clk) begin
        if (do_push) stk[sp_q[SIW-1:0]] <= pc_inc;
    end

endmodule

// File: tb/tb_microc_stk.sv
// tb_microc_stk: directed + random bench for microc_stk against a queue-based reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: none; fixed cycle counts throughout.
module tb_microc_stk;
    localparam int DW = 8, PW = 10, IW = 16, NP = 4, SD = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [IW-1:0]   instr;
    logic            s_inc, s_inm, we3, s_e, s_s, s_src, s_call, s_ret;
    logic [2:0]      op;
    logic [NP*DW-1:0] d_in;
    logic [PW-1:0]   pc;
    logic [5:0]      opcode;
    logic            zero, stk_ovf, stk_unf;
    logic [NP*DW-1:0] d_out;
`ifdef MICROC_CARRY_EN
    logic            carry;
`endif

    always #5 clk = ~clk;

    microc_stk #(.DWIDTH(DW), .PC_W(PW), .IW(IW), .NPORTS(NP), .STACK_DEPTH(SD)) dut (
        .clk(clk), .reset(reset), .instr(instr), .s_inc(s_inc), .s_inm(s_inm),
        .we3(we3), .s_e(s_e), .s_s(s_s), .s_src(s_src), .s_call(s_call), .s_ret(s_ret),
        .op(op), .d_in(d_in), .pc(pc), .opcode(opcode), .zero(zero), .d_out(d_out),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf)
`ifdef MICROC_CARRY_EN
        , .carry(carry)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_regs [16];
    int m_out  [NP];
    int m_pc;
    int m_stk  [$];
    bit m_zero, m_carry, m_ovf, m_unf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int alu_ref(int f, int a, int b);
        case (f)
            0: return a;
            1: return 255 - a;
            2: return (a + b) % 256;
            3: return (a - b + 256) % 256;
            4: return a & b;
            5: return a | b;
            6: return (256 - a) % 256;
            default: return (256 - b) % 256;
        endcase
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        foreach (m_out[i]) m_out[i] = 0;
        m_pc = 0; m_zero = 0; m_carry = 0; m_ovf = 0; m_unf = 0;
        m_stk.delete();
    endtask

    // Apply the current inputs to the model as one instruction
    task automatic model_step();
        int wa, ra1, ra2, imm, oimm, tgt, prt, a, b, r, nxt;
        wa = instr[15:12]; ra2 = instr[11:8]; ra1 = instr[7:4];
        imm = instr[11:4]; oimm = instr[15:8]; tgt = instr[15:6]; prt = instr[7:6];
        a = m_regs[ra1]; b = m_regs[ra2];
        r = alu_ref(int'(op), a, b);
        if (we3 && !s_e && !s_inm) begin
            m_zero  = (r == 0);
            m_carry = (op == 3'd2) ? (a + b > 255) : (op == 3'd3) ? (a >= b) : 1'b0;
        end
        if (we3 && wa != 0) m_regs[wa] = s_e ? int'(d_in[prt*8 +: 8]) : (s_inm ? imm : r);
        if (s_s) m_out[prt] = s_src ? b : oimm;
        nxt = (m_pc + 1) % 1024;
        if (s_call) begin
            if (m_stk.size() < SD) m_stk.push_back(nxt);
            else m_ovf = 1;
            m_pc = tgt;
        end else if (s_ret && m_stk.size() > 0) begin
            m_pc = m_stk.pop_back();
        end else if (s_ret) begin
            m_pc = nxt;
            m_unf = 1;
        end else begin
            m_pc = s_inc ? nxt : tgt;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e;
        for (int k = 0; k < NP; k++) e[k*8 +: 8] = m_out[k][7:0];
        chk({tag, ".pc"}, 64'(pc), 64'(m_pc));
        chk({tag, ".zero"}, 64'(zero), 64'(m_zero));
        chk({tag, ".d_out"}, 64'(d_out), 64'(e));
        chk({tag, ".ovf"}, 64'(stk_ovf), 64'(m_ovf));
        chk({tag, ".unf"}, 64'(stk_unf), 64'(m_unf));
`ifdef MICROC_CARRY_EN
        chk({tag, ".carry"}, 64'(carry), 64'(m_carry));
`endif
    endtask

    task automatic cycle(input string tag);
        chk({tag, ".opcode"}, 64'(opcode), 64'(instr[5:0]));
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        s_inc = 0; s_inm = 0; we3 = 0; s_e = 0; s_s = 0; s_src = 0;
        s_call = 0; s_ret = 0; op = 3'd0;
    endtask

    int ret_addr [SD];
    int prev_pc;

    initial begin
        // Reset state
        idle();
        instr = '0; d_in = '0;
        reset = 1'b0;
        #12;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Sequential fetch
        for (int i = 1; i <= 5; i++) begin
            s_inc = 1;
            cycle("inc");
            chk("pc_step", 64'(pc), 64'(i));
        end

        // Immediate loads, add to zero, zero holds across immediate write
        we3 = 1; s_inm = 1; instr = 16'h10F0; cycle("ld_r1");
        instr = 16'h2F10; cycle("ld_r2");
        s_inm = 0; op = 3'b010; instr = 16'h3210; cycle("add_r3");
        chk("zero_after_add", 64'(zero), 64'd1);
`ifdef MICROC_CARRY_EN
        chk("carry_after_add", 64'(carry), 64'd1);
`endif
        s_inm = 1; instr = 16'h4550; cycle("ld_r4");
        chk("zero_held", 64'(zero), 64'd1);

        // Input port to register, register to output port
        s_inm = 0; s_e = 1; d_in = 32'h00A5_0000; instr = 16'h5080; cycle("port_in");
        we3 = 0; s_e = 0; s_s = 1; s_src = 1; instr = 16'h05C0; cycle("port_out");
        chk("d_out3", 64'(d_out[31:24]), 64'hA5);
        chk("d_out_others", 64'(d_out[23:0]), 64'h0);

        // Jump, call, ret
        s_s = 0; s_src = 0; s_inc = 0; instr = 16'h0400; cycle("jump");
        chk("jump_pc", 64'(pc), 64'h010);
        s_call = 1; instr = 16'h8000; cycle("call");
        chk("call_pc", 64'(pc), 64'h200);
        s_call = 0; s_ret = 1; cycle("ret");
        chk("ret_pc", 64'(pc), 64'h011);

        // Nested calls to full depth, overflow, unwind, underflow
        s_ret = 0; s_call = 1;
        for (int i = 0; i < SD; i++) begin
            ret_addr[i] = (m_pc + 1) % 1024;
            instr = 16'($urandom);
            cycle("nest_call");
        end
        instr = 16'hABC0; cycle("ovf_call");
        chk("ovf_jump", 64'(pc), 64'h2AF);
        chk("ovf_flag", 64'(stk_ovf), 64'd1);
        s_call = 0; s_ret = 1;
        for (int i = SD - 1; i >= 0; i--) begin
            cycle("nest_ret");
            chk("nest_ret_addr", 64'(pc), 64'(ret_addr[i]));
        end
        s_inc = 1; prev_pc = m_pc; cycle("unf_ret");
        chk("unf_pc", 64'(pc), 64'((prev_pc + 1) % 1024));
        chk("unf_flag", 64'(stk_unf), 64'd1);

        // PC wrap and call+ret collision
        s_ret = 0; s_inc = 0; instr = 16'hFFC0; cycle("to_top");
        chk("top_pc", 64'(pc), 64'h3FF);
        s_inc = 1; cycle("wrap");
        chk("wrap_pc", 64'(pc), 64'h000);
        s_call = 1; s_ret = 1; instr = 16'h1240; cycle("call_ret");
        chk("call_ret_pc", 64'(pc), 64'h049);
        s_call = 0; cycle("ret_after");
        chk("ret_after_pc", 64'(pc), 64'h001);

        // Random instruction stream
        for (int n = 0; n < 400; n++) begin
            instr  = 16'($urandom);
            op     = 3'($urandom);
            d_in   = 32'($urandom);
            s_inc  = ($urandom_range(0, 3) != 0);
            s_inm  = 1'($urandom);
            we3    = 1'($urandom);
            s_e    = ($urandom_range(0, 3) == 0);
            s_s    = 1'($urandom);
            s_src  = 1'($urandom);
            s_call = ($urandom_range(0, 7) == 0);
            s_ret  = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        // Asynchronous reset in the middle of a call
        idle();
        s_call = 1; instr = 16'h8000;
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        reset = 1'b1;
        s_call = 0; s_ret = 1; s_inc = 1;
        cycle("post_rst_ret");
        chk("push_discarded", 64'(stk_unf), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
